// File: rtl/refill_mem_responder_pkg.sv
// Shared types and constants for the i-cache refill memory responder.
package refill_mem_responder_pkg;
  localparam int ISA_XLEN = 32;
  localparam logic [1:0] LAST_BEAT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BEAT  = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;
endpackage

// File: rtl/refill_ram.sv
// Backing store: one synchronous write port, one registered read port.
// On a same-address collision the read returns the word from before the write.
module refill_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data
);
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between reads so the output stays stable.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/refill_mem_responder.sv
// Returns a 16-byte cache line as four single-cycle ack/data beats after a
// programmable latency, with optional idle gaps between beats.
module refill_mem_responder
  import refill_mem_responder_pkg::*;
#(
  parameter int XLEN        = ISA_XLEN,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3,
  parameter int BEAT_GAP    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_req,
  input  logic [XLEN-1:0] mem_addr,
  output logic            mem_ack,
  output logic [XLEN-1:0] mem_data,
  output logic            busy,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int MAXCNT = (LATENCY > BEAT_GAP) ? LATENCY : BEAT_GAP;
  localparam int CW     = $clog2(MAXCNT + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [1:0]      beat_q, beat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   rd_addr;
  logic            unused_addr_bits;

  // Only the word-index bits of either address matter; the rest alias.
  assign unused_addr_bits = ^{mem_addr, wr_addr};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (mem_req) begin
        state_d = S_WAIT;
        base_d  = mem_addr[AW+1:2] & ~AW'(3);
        beat_d  = '0;
        cnt_d   = CW'(LATENCY - 1);
      end
      S_WAIT: begin
        if (!mem_req) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          state_d = S_BEAT;
          ack_d   = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_BEAT: begin
        if (!mem_req) state_d = S_IDLE;
        else if (beat_q == LAST_BEAT) state_d = S_DRAIN;
        else begin
          beat_d = beat_q + 2'd1;
          if (BEAT_GAP == 0) ack_d = 1'b1;
          else begin
            state_d = S_GAP;
            cnt_d   = CW'(BEAT_GAP - 1);
          end
        end
      end
      S_GAP: begin
        if (!mem_req) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          state_d = S_BEAT;
          ack_d   = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_DRAIN: if (!mem_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // The read is launched on the same edge that raises ack, so data and ack align.
  assign rd_addr = base_q + AW'(beat_d);

  refill_ram #(.XLEN(XLEN), .DEPTH(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr[AW+1:2]),
    .wr_data (wr_data),
    .rd_en   (ack_d),
    .rd_addr (rd_addr),
    .rd_data (mem_data)
  );

  assign mem_ack = ack_q;
  assign busy    = busy_q;
endmodule

// File: doc/refill_mem_responder.md
# refill_mem_responder

Memory-side responder for the instruction-cache line-refill protocol. It accepts a line request (`mem_req` + `mem_addr`), then returns the four 32-bit words of the 16-byte-aligned line as four single-cycle `mem_ack`/`mem_data` beats after a programmable latency. It backs the refill path in simulation and FPGA builds with a word-addressed RAM that the testbench or loader preloads through a write port.

## Interface
- `XLEN`, 32: data/address width.
- `DEPTH_WORDS`, 1024: backing-store words; power of two, ≥ 4.
- `LATENCY`, 3: cycles from request acceptance to first beat; ≥ 1.
- `BEAT_GAP`, 0: idle cycles inserted between consecutive beats; ≥ 0.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_req` in 1: line request, held high by the initiator for the whole burst.
- `mem_addr` in XLEN: byte address; sampled only on request acceptance.
- `mem_ack` out 1: one-cycle pulse per returned word.
- `mem_data` out XLEN: word for the current beat, valid only while `mem_ack` = 1.
- `busy` out 1: high from acceptance until return to IDLE.
- `wr_en` in 1: preload write strobe.
- `wr_addr` in XLEN: preload byte address; bits [1:0] ignored.
- `wr_data` in XLEN: preload word.

## Operation
- States: IDLE, WAIT, BEAT, GAP, DRAIN.
- IDLE:
  - On `mem_req` = 1 at an edge, accept the request.
  - Latch `base = {mem_addr[XLEN-1:4], 4'b0}`, clear `beat` (2 bits), load the latency counter, and go to WAIT.
- WAIT:
  - Count down.
  - First `mem_ack` is high in exactly the cycle after the LATENCY-th edge following acceptance (acceptance edge = edge 0).
- BEAT:
  - Drive `mem_ack` = 1 and `mem_data = ram[((base>>2) + beat) mod DEPTH_WORDS]`.
  - Beat index uses bits [log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses alias and wrap.
  - After beat 3, go to DRAIN. Otherwise increment `beat` and go to GAP (if BEAT_GAP > 0) or stay in BEAT.
- GAP: hold `mem_ack` = 0 for BEAT_GAP cycles, then return to BEAT.
- DRAIN:
  - `mem_ack` = 0; wait until `mem_req` = 0, then go to IDLE.
  - A new request is accepted only from IDLE, so `mem_req` must be seen low for at least one cycle between bursts.
- The initiator's running `mem_addr` increments are ignored; the beat address is generated internally.
- Abort: if `mem_req` falls in WAIT, BEAT, or GAP, go to IDLE at that edge with `mem_ack` = 0. Remaining beats are dropped.
- Preload:
  - `wr_en` writes `ram[wr_addr[log2(DEPTH_WORDS)+1:2]]` synchronously in any state.
  - A read in the same cycle as a write to the same word returns the old word.
  - Writes from earlier cycles are visible.
- Backing store initialises to zero in simulation; RAM contents are not affected by `reset`.

## Timing
- Reset values: `mem_ack` = 0, `mem_data` = 0, `busy` = 0, state IDLE, `beat` = 0, counters 0.
- Reset asserted mid-burst returns the block to IDLE immediately; no further acks are issued.
- `mem_ack` and `mem_data` are registered outputs with no combinational path from inputs.
- Burst length with BEAT_GAP = 0: acks in cycles L, L+1, L+2, L+3 after acceptance.
- General case: beats are separated by 1+BEAT_GAP cycles.
- `busy` rises the cycle after acceptance and falls the cycle after DRAIN exits.
- Outside ack cycles, `mem_data` holds its last value.

## Structure
- Shared `isa.v` supplies `XLEN`.
- State encodings are localparams.
- One sub-module, `refill_ram`: single-port-write / single-port-read synchronous RAM (DEPTH_WORDS × XLEN) with read-old-on-collision behaviour.

## Test plan
- Preload words 0x100..0x10C with 0xA0..0xA3. Request `mem_addr` = 0x104 with LATENCY 3, BEAT_GAP 0 → acks in cycles 3, 4, 5, 6 with data A0, A1, A2, A3. `busy` then drops after `mem_req` falls.
- BEAT_GAP = 2, same line → acks at cycles 3, 6, 9, 12; `mem_ack` is low in between.
- Request at byte 0xFF0 with DEPTH_WORDS 1024 (index 1020..1023), then at 0x1000 → the second request returns `ram[0..3]` (aliasing/wrap).
- Drop `mem_req` after the second ack → no third ack. An immediate re-request after one low cycle is accepted and returns the full line.
- Assert `reset` during the WAIT countdown → no ack ever appears, and all outputs read zero during reset.
- Write 0xDEAD to the word being read in its beat cycle → that beat returns the old value; a re-request returns 0xDEAD.
